// File: rtl/falafel_lsu.sv
// falafel_lsu: translates one header_req_t at a time into word accesses on a single-master memory port.
// Latency (zero-wait memory, accept = cycle 0): LOAD 5, EDIT_SIZE_AND_NEXT_ADDR 3, EDIT_NEXT_ADDR 2, UNLOCK 2, LOCK (free) 4.
// Backpressure: lsu_ready_o is high only in IDLE; memory requests hold stable until mem_gnt_i, one transaction outstanding.
//
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   req_from_core_i / lsu_ready_o  core request {header, lsu_op, val} and accept qualifier
//   rsp_to_core_o                  {header, val}; val pulses for one cycle on completion
//   mem_*                          single-master memory port; mem_excl_o locks the arbiter during LOCK

package falafel_pkg;
    localparam int DATA_W = 32;

    typedef logic [2:0] lsu_op_t;
    localparam lsu_op_t OP_LOAD           = 3'd0;
    localparam lsu_op_t OP_EDIT_SIZE_NEXT = 3'd1;
    localparam lsu_op_t OP_EDIT_NEXT      = 3'd2;
    localparam lsu_op_t OP_LOCK           = 3'd3;
    localparam lsu_op_t OP_UNLOCK         = 3'd4;

    typedef struct packed {
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] size;
        logic [DATA_W-1:0] next_addr;
    } header_t;

    typedef struct packed {
        header_t header;
        lsu_op_t lsu_op;
        logic    val;
    } header_req_t;

    typedef struct packed {
        header_t header;
        logic    val;
    } header_rsp_t;
endpackage

module falafel_lsu #(
    parameter int                DATA_W       = falafel_pkg::DATA_W,
    parameter int                WORD_BYTES   = DATA_W / 8,
    parameter logic [DATA_W-1:0] LOCK_ADDR    = '0,
    parameter int                RETRY_CYCLES = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  falafel_pkg::header_req_t req_from_core_i,
    output logic                     lsu_ready_o,
    output falafel_pkg::header_rsp_t rsp_to_core_o,
    output logic                     mem_req_o,
    output logic                     mem_we_o,
    output logic [DATA_W-1:0]        mem_addr_o,
    output logic [DATA_W-1:0]        mem_wdata_o,
    output logic                     mem_excl_o,
    input  logic                     mem_gnt_i,
    input  logic                     mem_rvalid_i,
    input  logic [DATA_W-1:0]        mem_rdata_i
);

    localparam logic [3:0] IDLE       = 4'd0;
    localparam logic [3:0] RD_SIZE    = 4'd1;
    localparam logic [3:0] RD_SIZE_W  = 4'd2;
    localparam logic [3:0] RD_NEXT    = 4'd3;
    localparam logic [3:0] RD_NEXT_W  = 4'd4;
    localparam logic [3:0] WR_SIZE    = 4'd5;
    localparam logic [3:0] WR_NEXT    = 4'd6;
    localparam logic [3:0] LK_RD      = 4'd7;
    localparam logic [3:0] LK_RD_W    = 4'd8;
    localparam logic [3:0] LK_WR      = 4'd9;
    localparam logic [3:0] LK_BACKOFF = 4'd10;
    localparam logic [3:0] UNLK_WR    = 4'd11;
    localparam logic [3:0] RSP        = 4'd12;

    localparam int CNT_W = (RETRY_CYCLES > 1) ? $clog2(RETRY_CYCLES) : 1;

    logic [3:0]                state_q;
    falafel_pkg::header_t      hdr_q;
    falafel_pkg::lsu_op_t      op_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [DATA_W-1:0]         next_field_addr;
    logic                      echo_hdr;

    // next_addr field sits one word above the header; wraps modulo 2^DATA_W.
    assign next_field_addr = hdr_q.addr + DATA_W'(WORD_BYTES);

    // Only header ops return a header; LOCK/UNLOCK/unknown ops return zero.
    assign echo_hdr = (op_q == falafel_pkg::OP_LOAD) ||
                      (op_q == falafel_pkg::OP_EDIT_SIZE_NEXT) ||
                      (op_q == falafel_pkg::OP_EDIT_NEXT);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            hdr_q   <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_from_core_i.val) begin
                        hdr_q <= req_from_core_i.header;
                        op_q  <= req_from_core_i.lsu_op;
                        case (req_from_core_i.lsu_op)
                            falafel_pkg::OP_LOAD:           state_q <= RD_SIZE;
                            falafel_pkg::OP_EDIT_SIZE_NEXT: state_q <= WR_SIZE;
                            falafel_pkg::OP_EDIT_NEXT:      state_q <= WR_NEXT;
                            falafel_pkg::OP_LOCK:           state_q <= LK_RD;
                            falafel_pkg::OP_UNLOCK:         state_q <= UNLK_WR;
                            default:                        state_q <= RSP;
                        endcase
                    end
                end
                RD_SIZE:   if (mem_gnt_i) state_q <= RD_SIZE_W;
                RD_SIZE_W: begin
                    if (mem_rvalid_i) begin
                        hdr_q.size <= mem_rdata_i;
                        state_q    <= RD_NEXT;
                    end
                end
                RD_NEXT:   if (mem_gnt_i) state_q <= RD_NEXT_W;
                RD_NEXT_W: begin
                    if (mem_rvalid_i) begin
                        hdr_q.next_addr <= mem_rdata_i;
                        state_q         <= RSP;
                    end
                end
                WR_SIZE:   if (mem_gnt_i) state_q <= WR_NEXT;
                WR_NEXT:   if (mem_gnt_i) state_q <= RSP;
                LK_RD:     if (mem_gnt_i) state_q <= LK_RD_W;
                LK_RD_W: begin
                    if (mem_rvalid_i) begin
                        if (mem_rdata_i == '0) begin
                            state_q <= LK_WR;
                        end else begin
                            cnt_q   <= CNT_W'(RETRY_CYCLES - 1);
                            state_q <= LK_BACKOFF;
                        end
                    end
                end
                LK_BACKOFF: begin
                    if (cnt_q == '0) state_q <= LK_RD;
                    else             cnt_q   <= cnt_q - 1'b1;
                end
                LK_WR:     if (mem_gnt_i) state_q <= RSP;
                UNLK_WR:   if (mem_gnt_i) state_q <= RSP;
                RSP:       state_q <= IDLE;
                default:   state_q <= IDLE;
            endcase
        end
    end

    // All outputs decode from state so reset clears them without waiting for a clock.
    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_excl_o  = 1'b0;
        case (state_q)
            RD_SIZE: begin
                mem_req_o  = 1'b1;
                mem_addr_o = hdr_q.addr;
            end
            RD_NEXT: begin
                mem_req_o  = 1'b1;
                mem_addr_o = next_field_addr;
            end
            WR_SIZE: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = hdr_q.addr;
                mem_wdata_o = hdr_q.size;
            end
            WR_NEXT: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = next_field_addr;
                mem_wdata_o = hdr_q.next_addr;
            end
            LK_RD: begin
                mem_req_o  = 1'b1;
                mem_addr_o = LOCK_ADDR;
                mem_excl_o = 1'b1;
            end
            LK_RD_W: mem_excl_o = 1'b1;
            LK_WR: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = LOCK_ADDR;
                mem_wdata_o = DATA_W'(1);
                mem_excl_o  = 1'b1;
            end
            UNLK_WR: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = LOCK_ADDR;
            end
            default: ;
        endcase
    end

    always_comb begin
        lsu_ready_o          = (state_q == IDLE);
        rsp_to_core_o        = '0;
        rsp_to_core_o.val    = (state_q == RSP);
        if ((state_q == RSP) && echo_hdr) begin
            rsp_to_core_o.header = hdr_q;
        end
    end

endmodule

// File: tb/tb_falafel_lsu.sv
module tb_falafel_lsu;
    import falafel_pkg::*;

    localparam int RETRY = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    header_req_t req;
    header_rsp_t rsp;
    logic        lsu_ready, mem_req, mem_we, mem_excl, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk_i = ~clk_i;

    falafel_lsu #(
        .DATA_W(32), .WORD_BYTES(4), .LOCK_ADDR(32'h0), .RETRY_CYCLES(RETRY)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_from_core_i(req), .lsu_ready_o(lsu_ready), .rsp_to_core_o(rsp),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_excl_o(mem_excl),
        .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
    );

    // ---------------- stimulus-owned controls ----------------
    int          gnt_delay, rv_delay, lock_busy_n;
    header_t     cur_hdr;
    int          cur_lat;
    logic [31:0] wr_exp_addr [0:15];
    logic [31:0] wr_exp_dat  [0:15];
    int          wr_exp_n, exp_rsps, to_cnt;
    bit          lock_chk, no_mem, done;

    // ---------------- memory model ----------------
    logic [31:0] mem [0:63];
    bit          model_init;
    int          wcnt, lk_rd_cnt, rv_cnt;
    logic        rv_pend;
    logic [31:0] rv_dat;

    assign mem_gnt    = mem_req && (wcnt >= gnt_delay);
    assign mem_rvalid = rv_pend && (rv_cnt == 0);
    assign mem_rdata  = rv_dat;

    always @(posedge clk_i) begin
        if (!model_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[4]     <= 32'd40;
            mem[5]     <= 32'h80;
            rv_pend    <= 1'b0;
            rv_cnt     <= 0;
            rv_dat     <= 32'h0;
            wcnt       <= 0;
            lk_rd_cnt  <= 0;
            model_init <= 1'b1;
        end else begin
            if (rv_pend) begin
                if (rv_cnt == 0) rv_pend <= 1'b0;
                else             rv_cnt  <= rv_cnt - 1;
            end
            if (mem_req && mem_gnt) begin
                wcnt <= 0;
                if (mem_we) begin
                    mem[mem_addr[7:2]] <= mem_wdata;
                end else begin
                    rv_pend <= 1'b1;
                    rv_cnt  <= rv_delay;
                    if (mem_addr == 32'h0 && lk_rd_cnt < lock_busy_n) rv_dat <= 32'h1;
                    else                                               rv_dat <= mem[mem_addr[7:2]];
                    if (mem_addr == 32'h0) lk_rd_cnt <= lk_rd_cnt + 1;
                end
            end else if (mem_req) begin
                wcnt <= wcnt + 1;
            end else begin
                wcnt <= 0;
            end
        end
    end

    // ---------------- scoreboard / monitor ----------------
    typedef struct {
        header_t hdr;
        int      lat;
    } exp_t;

    exp_t        exp_q[$];
    int          acc_q[$];
    int          cyc;
    int          n_chk, n_fail;
    int          wr_pop, rsp_cnt, lk_reads, last_lk;
    bit          outstanding, prev_pend, finished;
    logic [65:0] prev_vec;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial last_lk = -1;

    always @(negedge clk_i) begin
        if (!rst_ni) begin
            chk("rst_ready", 128'(lsu_ready), 128'(1));
            chk("rst_mem_req", 128'(mem_req), 128'(0));
            chk("rst_excl", 128'(mem_excl), 128'(0));
            chk("rst_rsp", 128'(rsp), 128'(0));
            chk("rst_we_addr_wdata", {mem_we, mem_addr, mem_wdata}, 128'(0));
            exp_q.delete();
            acc_q.delete();
            outstanding = 1'b0;
            prev_pend   = 1'b0;
        end else begin
            if (outstanding) chk("busy_ready", 128'(lsu_ready), 128'(0));
            if (rsp.val) begin
                rsp_cnt++;
                chk("rsp_has_exp", 128'(exp_q.size() != 0), 128'(1));
                if (exp_q.size() != 0) begin
                    exp_t e;
                    int   a;
                    e = exp_q.pop_front();
                    a = acc_q.pop_front();
                    chk("rsp_header", 128'(rsp.header), 128'(e.hdr));
                    if (e.lat >= 0) chk("rsp_latency", 128'(cyc - a), 128'(e.lat));
                end
                outstanding = 1'b0;
            end
            if (req.val && lsu_ready) begin
                exp_q.push_back('{cur_hdr, cur_lat});
                acc_q.push_back(cyc);
                outstanding = 1'b1;
            end
            if (mem_req && mem_gnt && mem_we) begin
                chk("wr_expected", 128'(wr_pop < wr_exp_n), 128'(1));
                if (wr_pop < wr_exp_n) begin
                    chk("wr_addr", 128'(mem_addr), 128'(wr_exp_addr[wr_pop]));
                    chk("wr_data", 128'(mem_wdata), 128'(wr_exp_dat[wr_pop]));
                end
                wr_pop++;
            end
            if (prev_pend) chk("req_stable", 128'({mem_req, mem_we, mem_addr, mem_wdata}), 128'(prev_vec));
            prev_pend = mem_req && !mem_gnt;
            prev_vec  = {mem_req, mem_we, mem_addr, mem_wdata};
            if (lock_chk) begin
                chk("excl_lock", 128'(mem_excl), 128'(mem_req | mem_rvalid));
                if (mem_req && mem_gnt && !mem_we && mem_addr == 32'h0) begin
                    if (last_lk >= 0) chk("lock_gap", 128'((cyc - last_lk) >= RETRY + 2), 128'(1));
                    last_lk = cyc;
                    lk_reads++;
                end
            end else begin
                chk("excl_idle", 128'(mem_excl), 128'(0));
                last_lk = -1;
            end
            if (no_mem) chk("no_mem_req", 128'(mem_req), 128'(0));
        end
        if (done && !finished) begin
            finished = 1'b1;
            chk("lock_reads", 128'(lk_reads), 128'(3));
            chk("rsp_count", 128'(rsp_cnt), 128'(exp_rsps));
            chk("writes_done", 128'(wr_pop), 128'(wr_exp_n));
            chk("timeouts", 128'(to_cnt), 128'(0));
            chk("exp_q_empty", 128'(exp_q.size()), 128'(0));
            $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
            $finish;
        end
    end

    // ---------------- stimulus ----------------
    function automatic header_t mk(input logic [31:0] a, input logic [31:0] s, input logic [31:0] n);
        header_t h;
        h.addr = a; h.size = s; h.next_addr = n;
        return h;
    endfunction

    task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
        wr_exp_addr[wr_exp_n] = a;
        wr_exp_dat[wr_exp_n]  = d;
        wr_exp_n++;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        do begin
            @(negedge clk_i); #1;
            n++;
        end while (outstanding && n < 200);
        if (outstanding) begin
            to_cnt++;
            $display("timeout waiting for response at cycle %0d", cyc);
        end
        repeat (2) @(posedge clk_i);
    endtask

    task automatic issue(input lsu_op_t op, input header_t h, input header_t eh,
                         input int lat, input bit wait_rsp);
        int n;
        cur_hdr = eh;
        cur_lat = lat;
        @(posedge clk_i); #1;
        req.header = h;
        req.lsu_op = op;
        req.val    = 1'b1;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!lsu_ready && n < 50);
        if (!lsu_ready) begin
            to_cnt++;
            $display("timeout waiting for lsu_ready at cycle %0d", cyc);
        end
        @(posedge clk_i); #1;
        req.val = 1'b0;
        if (wait_rsp) begin
            exp_rsps++;
            wait_done();
        end
    endtask

    initial begin
        int n;
        rst_ni = 1'b0;
        req    = '0;
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        repeat (2) @(posedge clk_i);

        // LOAD, zero-wait: header fields come from memory, not the request
        issue(OP_LOAD, mk(32'h10, 32'hdead, 32'hbeef), mk(32'h10, 32'd40, 32'h80), 5, 1);

        // EDIT_SIZE_AND_NEXT_ADDR with 3-cycle grant stalls
        gnt_delay = 3;
        push_wr(32'h60, 32'd24);
        push_wr(32'h64, 32'h0);
        issue(OP_EDIT_SIZE_NEXT, mk(32'h60, 32'd24, 32'h0), mk(32'h60, 32'd24, 32'h0), 9, 1);
        gnt_delay = 0;

        // EDIT_NEXT_ADDR: single write of the next_addr word
        push_wr(32'h14, 32'h60);
        issue(OP_EDIT_NEXT, mk(32'h10, 32'h999, 32'h60), mk(32'h10, 32'h999, 32'h60), 2, 1);

        // LOCK: busy for two reads, then free; then UNLOCK
        lock_busy_n = 2;
        lock_chk    = 1'b1;
        push_wr(32'h0, 32'h1);
        issue(OP_LOCK, mk(32'h44, 32'h55, 32'h66), '0, 16, 1);
        lock_chk = 1'b0;
        push_wr(32'h0, 32'h0);
        issue(OP_UNLOCK, mk(32'h44, 32'h55, 32'h66), '0, 2, 1);

        // next_addr field address wraps past the top of the address space
        push_wr(32'h0, 32'h123);
        issue(OP_EDIT_NEXT, mk(32'hFFFF_FFFC, 32'h7, 32'h123), mk(32'hFFFF_FFFC, 32'h7, 32'h123), 2, 1);

        // Reset while waiting for read data; the late rvalid must be ignored
        rv_delay = 3;
        issue(OP_LOAD, mk(32'h10, 32'h0, 32'h0), mk(32'h10, 32'd40, 32'h60), 5, 0);
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!(mem_req && mem_gnt) && n < 20);
        if (!(mem_req && mem_gnt)) begin
            to_cnt++;
            $display("timeout waiting for read grant at cycle %0d", cyc);
        end
        @(posedge clk_i); #2;
        rst_ni = 1'b0;
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        repeat (8) @(posedge clk_i);
        rv_delay = 0;
        issue(OP_LOAD, mk(32'h10, 32'h0, 32'h0), mk(32'h10, 32'd40, 32'h60), 5, 1);

        // Unknown op, val held high: accepted only while ready, no memory traffic
        cur_hdr = '0;
        cur_lat = 1;
        no_mem  = 1'b1;
        @(posedge clk_i); #1;
        req.header = mk(32'h70, 32'h71, 32'h72);
        req.lsu_op = 3'd7;
        req.val    = 1'b1;
        repeat (4) @(posedge clk_i);
        #1 req.val = 1'b0;
        exp_rsps += 2;
        wait_done();
        no_mem = 1'b0;

        @(posedge clk_i);
        done = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: test did not complete by %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
